sseg4_scan_ctrl: RTL and testbench

//  Sequencer for the 4-digit seven-segment display path.
//  - Accepts an 11-bit binary value over a valid/ready handshake.
//  - Converts it to four BCD digits serially: shift-add-3, one bit per clock.
//  - Holds the digits in a display register.
//  - Time-multiplexes the digits onto the shared seg bus by scanning the anodes.
//  - Sits between switch/user logic and the board display pins; replaces static single-digit anode selection.

---
 rtl/sseg4_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sseg4_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg4_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg4_scan_ctrl
//   Four-digit seven-segment display sequencer. An 11-bit binary value is
//   accepted over a valid/ready handshake and converted serially to four BCD
//   digits (shift-add-3, one bit per clock). The digits are then held in a
//   display register. A free-running refresh divider scans the digits onto
//   the shared active-low seg bus, driving one active-low anode at a time.
//
// Parameters
//   DIV_W     refresh divider width; each digit is lit for 2**DIV_W cycles
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_data   unsigned binary value to display (0..2047)
//   in_valid  in_data valid
//   in_ready  block can accept in_data (low while converting)
//   an        anode enables, active-low, an[0] = ones digit
//   seg       segments a..g on seg[0]..seg[6], active-low
//   dp        decimal point, active-low, always off
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant
//                          nonzero digit are blanked (an=1111, seg=1111111).
//                          The ones digit is always shown.
// ---------------------------------------------------------------------------
module sseg4_scan_ctrl #(
    parameter int DIV_W = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        shift_q, shift_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        disp_q, disp_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [15:0]        adj_s;
    logic [3:0]         digit_s;

    // Add 3 to every nibble that is 5 or more; nibbles never carry into each other.
    function automatic logic [15:0] add3_nibbles(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // BCD digit to active-low segment pattern; non-decimal codes are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Index of the most-significant nonzero digit; 0 when the value is zero.
    function automatic logic [1:0] msd_index(input logic [15:0] d);
        logic [1:0] m;
        if (d[15:12] != 4'd0) begin
            m = 2'd3;
        end else if (d[11:8] != 4'd0) begin
            m = 2'd2;
        end else if (d[7:4] != 4'd0) begin
            m = 2'd1;
        end else begin
            m = 2'd0;
        end
        return m;
    endfunction
`endif

    // Conversion FSM: load on accept, then 11 add-3/shift steps and commit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        adj_s   = add3_nibbles(bcd_q);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_d = in_data;
                    bcd_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                // The shifted-out top bit of the thousands nibble is always
                // zero because the thousands digit never exceeds 2.
                {bcd_d, shift_d} = {adj_s, shift_q} << 1;
                cnt_d            = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    disp_d  = bcd_d;
                    state_d = IDLE;
                end else begin
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // Refresh scan: outputs are computed from next-cycle index and display so
    // the registered an/seg always match the index and digit held after the edge.
    always_comb begin
        div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        if (&div_q) begin
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
        digit_s = disp_d[{idx_d, 2'b00} +: 4];
        an_d    = ~(4'b0001 << idx_d);
        seg_d   = seg_decode(digit_s);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d > msd_index(disp_d)) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d  = ~(4'b0001 << idx_d);
        end
`endif
    end

    // State, datapath and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= 11'd0;
            bcd_q      <= 16'd0;
            cnt_q      <= 4'd0;
            disp_q     <= 16'd0;
            div_q      <= '0;
            idx_q      <= 2'd0;
            in_ready_q <= 1'b1;
            an_q       <= 4'b1110;
            seg_q      <= 7'b1000000;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign in_ready = in_ready_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sseg4_scan_ctrl
//   Self-checking bench for sseg4_scan_ctrl with DIV_W=2. Accepted values are
//   pushed to a scoreboard queue; when in_ready returns the expected value is
//   popped and becomes the reference for the scanned an/seg outputs. Digits
//   are derived arithmetically and the scan index by a small cycle model.
// ---------------------------------------------------------------------------
module tb_sseg4_scan_ctrl;

    localparam int DIV_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] in_data = 11'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          total = 0;
    int          bad = 0;
    logic [10:0] sb_q[$];
    logic [10:0] cur_disp = 11'd0;
    logic [DIV_W-1:0] m_div;
    logic [1:0]  m_idx;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    sseg4_scan_ctrl #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Reference scan position: free-running divider, index steps on all-ones.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= '0;
            m_idx <= 2'd0;
        end else begin
            m_div <= m_div + 1'b1;
            if (&m_div) m_idx <= m_idx + 2'd1;
        end
    end

    function automatic logic [3:0] dig(input logic [10:0] v, input logic [1:0] i);
        int x;
        x = int'(v);
        case (i)
            2'd0:    return 4'(x % 10);
            2'd1:    return 4'((x / 10) % 10);
            2'd2:    return 4'((x / 100) % 10);
            default: return 4'(x / 1000);
        endcase
    endfunction

    function automatic bit blanked(input logic [10:0] v, input logic [1:0] i);
`ifdef LEADING_ZERO_BLANK_EN
        int msd;
        msd = (v >= 11'd1000) ? 3 : (v >= 11'd100) ? 2 : (v >= 11'd10) ? 1 : 0;
        return int'(i) > msd;
`else
        return (v > 11'd2047) && (i == 2'd3);
`endif
    endfunction

    function automatic logic [3:0] exp_an(input logic [10:0] v, input logic [1:0] i);
        logic [3:0] one;
        one = 4'b0001;
        return blanked(v, i) ? 4'b1111 : ~(one << i);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [10:0] v, input logic [1:0] i);
        return blanked(v, i) ? 7'b1111111 : seg_tbl[dig(v, i)];
    endfunction

    // Wait (bounded) for in_ready, then present v for one accept edge.
    task automatic drive_accept(input logic [10:0] v, input bit keep);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait in_ready=%b required 1", in_ready);
        end
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(v);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    // Called at the first negedge after an accept: 11 busy cycles with the old
    // display still shown, then in_ready returns and the new value is popped.
    task automatic conv_wait(input string tag);
        for (int i = 0; i < 11; i++) begin
            total += 3;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_ready[%0d] got %b required 0", tag, i, in_ready);
            end
            if (an !== exp_an(cur_disp, m_idx)) begin
                bad++;
                $display("FAIL %s hold_an[%0d] got %b required %b", tag, i, an, exp_an(cur_disp, m_idx));
            end
            if (seg !== exp_seg(cur_disp, m_idx)) begin
                bad++;
                $display("FAIL %s hold_seg[%0d] got %b required %b", tag, i, seg, exp_seg(cur_disp, m_idx));
            end
            @(negedge clk);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_back got %b required 1", tag, in_ready);
        end
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard_empty got 0 entries required 1", tag);
        end else begin
            cur_disp = sb_q.pop_front();
        end
    endtask

    // Compare the scanned outputs against the current expected display.
    task automatic scan_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            total += 3;
            if (an !== exp_an(cur_disp, m_idx)) begin
                bad++;
                $display("FAIL %s an[%0d] value=%0d got %b required %b", tag, i, cur_disp, an, exp_an(cur_disp, m_idx));
            end
            if (seg !== exp_seg(cur_disp, m_idx)) begin
                bad++;
                $display("FAIL %s seg[%0d] value=%0d got %b required %b", tag, i, cur_disp, seg, exp_seg(cur_disp, m_idx));
            end
            if (dp !== 1'b1) begin
                bad++;
                $display("FAIL %s dp got %b required 1", tag, dp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #11;
        total += 4;
        if (an !== 4'b1110) begin bad++; $display("FAIL rst_an got %b required 1110", an); end
        if (seg !== 7'b1000000) begin bad++; $display("FAIL rst_seg got %b required 1000000", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp got %b required 1", dp); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b required 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        cur_disp = 11'd0;
        scan_check("post_reset", 10);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got %b required 1", in_ready); end
    endtask

    task automatic test_conversion();
        drive_accept(11'd1234, 1'b0);
        conv_wait("conv1234");
        scan_check("scan1234", 20);
    endtask

    task automatic test_max_and_zero();
        drive_accept(11'd2047, 1'b0);
        conv_wait("conv2047");
        scan_check("scan2047", 20);
        drive_accept(11'd0, 1'b0);
        conv_wait("conv0");
        scan_check("scan0", 20);
    endtask

    task automatic test_busy();
        drive_accept(11'd1234, 1'b1);
        in_data = 11'd5;
        conv_wait("busy1234");
        // valid is still high: the held value 5 is taken at the next edge
        @(posedge clk);
        sb_q.push_back(11'd5);
        @(negedge clk);
        in_valid = 1'b0;
        conv_wait("busy5");
        scan_check("scan5", 16);
    endtask

    task automatic test_back_to_back();
        drive_accept(11'd100, 1'b0);
        conv_wait("b2b100");
        drive_accept(11'd999, 1'b0);
        conv_wait("b2b999");
        scan_check("scan999", 16);
    endtask

    task automatic test_abort();
        drive_accept(11'd1234, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (an !== 4'b1110) begin bad++; $display("FAIL abort_an got %b required 1110", an); end
        if (seg !== 7'b1000000) begin bad++; $display("FAIL abort_seg got %b required 1000000", seg); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got %b required 1", in_ready); end
        void'(sb_q.pop_back());
        cur_disp = 11'd0;
        @(negedge clk);
        rst_n = 1'b1;
        scan_check("abort_scan", 16);
        drive_accept(11'd2047, 1'b0);
        conv_wait("abort_next");
        scan_check("abort_next_scan", 16);
    endtask

    task automatic test_blanking();
        drive_accept(11'd7, 1'b0);
        conv_wait("conv7");
        scan_check("scan7", 20);
        drive_accept(11'd40, 1'b0);
        conv_wait("conv40");
        scan_check("scan40", 16);
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_max_and_zero();
        test_busy();
        test_back_to_back();
        test_abort();
        test_blanking();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
